multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
Control FSM that sequences the rv32i datapath as a multi-cycle machine over a single unified memory port. It steps each instruction through fetch, decode, execute, memory and writeback, and issues one-cycle write strobes to the IR, PC and register file. It drives the memory request handshake, counts retired instructions, and halts on illegal opcode, ECALL/EBREAK or memory timeout. Per-instruction datapath controls (ALU source select, rd_select, branch) remain with the existing decoder; this block only gates them in time.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready; 0 disables the timeout.
INSTRET_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
opcode  input  7  instruction[6:0] from the IR; valid from DECODE onward
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request active
mem_addr_src  output  1  0 = pc, 1 = alu_result
mem_write_en  output  1  current request is a store
ir_write_en  output  1  latch fetched word into the IR
pc_write_en  output  1  load pc_next into the PC
rf_write_en  output  1  write rd
instr_retired  output  1  one-cycle pulse per completed instruction
instret  output  INSTRET_WIDTH  retired-instruction count
state  output  3  current FSM state encoding
halted  output  1  FSM is in TRAP
trap_cause  output  2  0 none, 1 illegal opcode, 2 memory timeout, 3 ECALL/EBREAK

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5.
- Reset (sampled on the clk edge with reset=1):
  - state<=FETCH; instret<=0; trap_cause<=0; internal class register and wait counter <=0.
  - While reset=1, all strobe and request outputs are forced to 0.
  - First cycle after reset deasserts: FETCH with mem_req=1.
- Strobes (ir/pc/rf_write_en, instr_retired) are combinational from state and inputs, one cycle wide.
- FETCH:
  - mem_req=1, mem_addr_src=0, mem_write_en=0.
  - When mem_ready=1: ir_write_en=1 that cycle, next state DECODE.
- DECODE: no strobes. Classify opcode into the internal class register:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP-IMM 0010011, OP 0110011 -> ALU class.
  - 1100011 -> BRANCH; 0000011 -> LOAD; 0100011 -> STORE; 0001111 -> FENCE; 1110011 -> SYSTEM.
  - Any other opcode -> TRAP with cause 1.
  - All legal classes go to EXECUTE.
- EXECUTE (one cycle):
  - ALU -> WRITEBACK.
  - LOAD/STORE -> MEMORY.
  - BRANCH and FENCE: pc_write_en=1, instr_retired=1, -> FETCH.
  - SYSTEM -> TRAP with cause 3; PC is not written and instr_retired stays 0.
- MEMORY:
  - mem_req=1, mem_addr_src=1, mem_write_en=1 only for STORE.
  - On mem_ready=1: STORE -> pc_write_en=1, instr_retired=1, -> FETCH; LOAD -> WRITEBACK.
- WRITEBACK: rf_write_en=1, pc_write_en=1, instr_retired=1, -> FETCH.
- TRAP: sticky until reset; halted=1; all strobes and mem_req are 0; trap_cause is held.
- Handshake rules:
  - mem_req, mem_addr_src and mem_write_en stay stable until the cycle mem_ready=1 (inclusive).
  - mem_ready is ignored outside FETCH and MEMORY.
- Timeout:
  - Wait counter clears on entry to FETCH or MEMORY and increments each requesting cycle with mem_ready=0.
  - If MEM_TIMEOUT>0 and the MEM_TIMEOUT-th consecutive requesting cycle has mem_ready=0, next state is TRAP with cause 2.
  - mem_ready=1 on that same cycle wins: normal completion, no trap.
- instret:
  - Increments by 1 on the edge ending any cycle with instr_retired=1.
  - Wraps modulo 2^INSTRET_WIDTH.
- Timing: best-case latency, with mem_ready=1 on the first request cycle, is ALU 4, BRANCH/FENCE 3, STORE 4, LOAD 5 cycles.
- Reset mid-operation: reset in any state (including TRAP or mid-request) returns to FETCH next cycle. No strobes are issued in the reset cycle. instret clears.

Test Plan:
- ADDI (opcode 0010011), mem_ready held 1 -> states 0,1,2,4,0. ir_write_en in cycle 1; rf_write_en, pc_write_en and instr_retired in cycle 4; instret=1.
- LW (0000011), fetch ready immediately, MEMORY with mem_ready low 2 cycles then high -> MEMORY lasts 3 cycles with mem_addr_src=1, mem_write_en=0; then WRITEBACK; total 7 cycles; instret=1.
- SW (0100011) then BEQ (1100011), mem_ready=1 -> SW: mem_write_en=1 in MEMORY, retires at cycle 4 with no rf_write_en. BEQ retires at cycle 3. instret=2.
- Opcode 0000000 in DECODE -> TRAP next cycle, halted=1, trap_cause=1. mem_req stays 0 for 10 further cycles; instret unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> mem_req high exactly 4 cycles, then TRAP, trap_cause=2. Repeat with mem_ready=1 on 4th cycle -> DECODE, no trap.
- reset=1 asserted while in MEMORY with mem_req high -> outputs 0 during the reset cycle. Next cycle state=FETCH, mem_addr_src=0, instret=0, trap_cause=0.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM for an rv32i datapath on a single unified memory port.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, issues one-cycle write strobes,
// runs the memory request handshake, counts retired instructions and traps on
// illegal opcodes, ECALL/EBREAK or a memory request that waits too long.
module multi_cycle_control #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_addr_src,
    output logic                     mem_write_en,
    output logic                     ir_write_en,
    output logic                     pc_write_en,
    output logic                     rf_write_en,
    output logic                     instr_retired,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic [2:0]               state,
    output logic                     halted,
    output logic [1:0]               trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALU    = 3'd0,
        C_BRANCH = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_FENCE  = 3'd4,
        C_SYSTEM = 3'd5
    } class_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_SYSTEM  = 2'd3
    } cause_t;

    // Wide enough to hold MEM_TIMEOUT-1 for any setting, including 0 and 1.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    state_t                   state_q, state_d;
    class_t                   cls_q, cls_d, op_cls;
    cause_t                   cause_q, cause_d;
    logic [WAIT_W-1:0]        wait_q;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic                     op_legal;
    logic                     timed_out;
    logic                     wait_inc;
    logic                     req_r, src_r, wr_r, ir_r, pc_r, rf_r, ret_r;

    // Classify the IR opcode into an instruction class.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        op_cls   = C_ALU;
        op_legal = 1'b1;
        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0010011, 7'b0110011: op_cls = C_ALU;
            7'b1100011:                         op_cls = C_BRANCH;
            7'b0000011:                         op_cls = C_LOAD;
            7'b0100011:                         op_cls = C_STORE;
            7'b0001111:                         op_cls = C_FENCE;
            7'b1110011:                         op_cls = C_SYSTEM;
            default:                            op_legal = 1'b0;
        endcase
    end

    // The current requesting cycle is the last one allowed and memory still is not ready.
    assign timed_out = (MEM_TIMEOUT > 0) && !mem_ready
                       && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state, class/cause capture and raw (ungated) control outputs.
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        cause_d  = cause_q;
        wait_inc = 1'b0;
        req_r    = 1'b0;
        src_r    = 1'b0;
        wr_r     = 1'b0;
        ir_r     = 1'b0;
        pc_r     = 1'b0;
        rf_r     = 1'b0;
        ret_r    = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_r = 1'b1;
                if (mem_ready) begin
                    ir_r    = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    cls_d   = op_cls;
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEMORY;
                    C_BRANCH, C_FENCE: begin
                        pc_r    = 1'b1;
                        ret_r   = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_SYSTEM: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_SYSTEM;
                    end
                    default: state_d = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                req_r = 1'b1;
                src_r = 1'b1;
                wr_r  = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_r    = 1'b1;
                        ret_r   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WRITEBACK: begin
                rf_r    = 1'b1;
                pc_r    = 1'b1;
                ret_r   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // State, class, cause, wait counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ALU;
            cause_q   <= CAUSE_NONE;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cause_q <= cause_d;
            // Any state change restarts the wait count, which covers entry to FETCH and MEMORY.
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (wait_inc) begin
                wait_q <= wait_q + WAIT_W'(1);
            end
            if (ret_r) begin
                instret_q <= instret_q + INSTRET_WIDTH'(1);
            end
        end
    end

    // Strobes and requests are suppressed while reset is held.
    assign mem_req       = req_r & ~reset;
    assign mem_addr_src  = src_r & ~reset;
    assign mem_write_en  = wr_r  & ~reset;
    assign ir_write_en   = ir_r  & ~reset;
    assign pc_write_en   = pc_r  & ~reset;
    assign rf_write_en   = rf_r  & ~reset;
    assign instr_retired = ret_r & ~reset;
    assign instret       = instret_q;
    assign state         = state_q;
    assign halted        = (state_q == S_TRAP);
    assign trap_cause    = cause_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control. Each instruction's expected
// per-cycle trace is built from its class and the memory wait it is given.
module tb_multi_cycle_control;

    localparam int TO = 4;
    localparam int IW = 4;

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_DEC   = 3'd1;
    localparam logic [2:0] ST_EXE   = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_TRAP  = 3'd5;

    localparam int CL_ILLEGAL = 0;
    localparam int CL_ALU     = 1;
    localparam int CL_BRANCH  = 2;
    localparam int CL_LOAD    = 3;
    localparam int CL_STORE   = 4;
    localparam int CL_FENCE   = 5;
    localparam int CL_SYSTEM  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          mem_req, mem_addr_src, mem_write_en;
    logic          ir_write_en, pc_write_en, rf_write_en, instr_retired;
    logic [IW-1:0] instret;
    logic [2:0]    state;
    logic          halted;
    logic [1:0]    trap_cause;
    logic [10:0]   obs;

    int            checks = 0;
    int            passed = 0;
    int            fails  = 0;
    int            trap_hold = 3;
    logic [IW-1:0] exp_instret = '0;
    logic [1:0]    exp_cause = 2'd0;

    multi_cycle_control #(.MEM_TIMEOUT(TO), .INSTRET_WIDTH(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_addr_src  (mem_addr_src),
        .mem_write_en  (mem_write_en),
        .ir_write_en   (ir_write_en),
        .pc_write_en   (pc_write_en),
        .rf_write_en   (rf_write_en),
        .instr_retired (instr_retired),
        .instret       (instret),
        .state         (state),
        .halted        (halted),
        .trap_cause    (trap_cause)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, mem_addr_src, mem_write_en, ir_write_en,
                  pc_write_en, rf_write_en, instr_retired, halted};

    function automatic logic [10:0] mk(input logic [2:0] st, input logic req, input logic src,
                                       input logic wr, input logic ir, input logic pc,
                                       input logic rf, input logic ret);
        return {st, req, src, wr, ir, pc, rf, ret, (st == ST_TRAP)};
    endfunction

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0010011, 7'b0110011: return CL_ALU;
            7'b1100011: return CL_BRANCH;
            7'b0000011: return CL_LOAD;
            7'b0100011: return CL_STORE;
            7'b0001111: return CL_FENCE;
            7'b1110011: return CL_SYSTEM;
            default:    return CL_ILLEGAL;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive mem_ready, compare at the falling edge, advance the model.
    task automatic do_cycle(input logic rdy, input logic [10:0] exp_vec);
        mem_ready = rdy;
        @(negedge clk);
        check("trace", 32'(obs), 32'(exp_vec));
        check("instret", 32'(instret), 32'(exp_instret));
        check("trap_cause", 32'(trap_cause), 32'(exp_cause));
        @(posedge clk);
        #1;
        if (exp_vec[1]) exp_instret = exp_instret + 1'b1;
    endtask

    // One reset cycle with mem_ready high: every strobe and request must stay low.
    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'(obs[7:1]), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        exp_instret = '0;
        exp_cause   = 2'd0;
    endtask

    task automatic enter_trap(input logic [1:0] cause);
        exp_cause = cause;
        for (int i = 0; i < trap_hold; i++) begin
            do_cycle(rnd_bit(), mk(ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // Expected trace for one instruction: fw/mw = not-ready cycles before mem_ready in
    // FETCH/MEMORY; rst_mem asserts reset on the second MEMORY cycle.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit rst_mem);
        int   cls;
        logic rdy;
        logic st;
        opcode = op;
        cls    = classify(op);
        st     = (cls == CL_STORE);
        for (int i = 0; i <= fw; i++) begin
            rdy = (i == fw);
            if (!rdy && i == TO - 1) begin
                do_cycle(1'b0, mk(ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                enter_trap(2'd2);
                return;
            end
            do_cycle(rdy, mk(ST_FETCH, 1'b1, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 1'b0));
        end
        do_cycle(rnd_bit(), mk(ST_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (cls == CL_ILLEGAL) begin
            enter_trap(2'd1);
            return;
        end
        if (cls == CL_BRANCH || cls == CL_FENCE) begin
            do_cycle(rnd_bit(), mk(ST_EXE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
            return;
        end
        do_cycle(rnd_bit(), mk(ST_EXE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (cls == CL_SYSTEM) begin
            enter_trap(2'd3);
            return;
        end
        if (cls == CL_LOAD || cls == CL_STORE) begin
            for (int i = 0; i <= mw; i++) begin
                if (rst_mem && i == 1) begin
                    do_reset();
                    return;
                end
                rdy = (i == mw);
                if (!rdy && i == TO - 1) begin
                    do_cycle(1'b0, mk(ST_MEM, 1'b1, 1'b1, st, 1'b0, 1'b0, 1'b0, 1'b0));
                    enter_trap(2'd2);
                    return;
                end
                do_cycle(rdy, mk(ST_MEM, 1'b1, 1'b1, st, 1'b0, rdy && st, 1'b0, rdy && st));
            end
            if (st) return;
        end
        do_cycle(rnd_bit(), mk(ST_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] ops [10];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011,
                7'b0110011, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111};
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'd0;
        @(posedge clk);
        #1;
        do_reset();

        // ADDI with memory always ready: states 0,1,2,4.
        run_instr(7'b0010011, 0, 0, 1'b0);
        check("instret_after_addi", 32'(instret), 32'd1);
        // LW with two not-ready MEMORY cycles.
        do_reset();
        run_instr(7'b0000011, 0, 2, 1'b0);
        check("instret_after_lw", 32'(instret), 32'd1);
        // SW then BEQ.
        do_reset();
        run_instr(7'b0100011, 0, 0, 1'b0);
        run_instr(7'b1100011, 0, 0, 1'b0);
        check("instret_after_sw_beq", 32'(instret), 32'd2);
        // Illegal opcode, held in TRAP for 10 cycles.
        trap_hold = 10;
        run_instr(7'b0000000, 0, 0, 1'b0);
        check("halted_illegal", 32'(halted), 32'd1);
        trap_hold = 3;
        // Fetch timeout, then fetch ready on the last allowed cycle.
        do_reset();
        run_instr(7'b0010011, 5, 0, 1'b0);
        do_reset();
        run_instr(7'b0010011, TO - 1, 0, 1'b0);
        // Memory timeout on a load.
        run_instr(7'b0000011, 0, 6, 1'b0);
        // ECALL/EBREAK.
        do_reset();
        run_instr(7'b1110011, 1, 0, 1'b0);
        // FENCE, then reset in the middle of a store request.
        do_reset();
        run_instr(7'b0001111, 2, 0, 1'b0);
        run_instr(7'b0100011, 0, 3, 1'b1);
        check("instret_after_mid_reset", 32'(instret), 32'd0);

        // Randomized legal instructions with random memory latency; instret wraps.
        for (int n = 0; n < 60; n++) begin
            run_instr(ops[$urandom_range(0, 9)], int'($urandom_range(0, TO - 1)),
                      int'($urandom_range(0, TO - 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
